// File: rtl/reward_unit_pkg.sv
// Shared constants, packet-type codes and FSM state encoding for the EER-RL reward unit.
package reward_pkg;

  localparam int unsigned WORD_WIDTH = 16;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHA  = 3'b001;
  localparam logic [2:0] PKT_JOIN = 3'b010;
  localparam logic [2:0] PKT_DATA = 3'b011;
  localparam logic [2:0] PKT_LOWE = 3'b101;
  localparam logic [2:0] PKT_INV  = 3'b111;

  localparam logic [15:0] BROADCAST_ID = 16'hFFFF;
  localparam logic [5:0]  NOT_FOUND    = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DECIDE,
    ST_WAIT_OK,
    ST_DONE
  } reward_state_t;

endpackage

// File: rtl/reward_unit_if.sv
// Request/reply bus of the reward unit: start pulse, send grant and the assembled reply packet.
interface reward_unit_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic                  en;
  logic                  okToSend;
  logic                  reward_done;
  logic [WORD_WIDTH-1:0] rSourceID;
  logic [WORD_WIDTH-1:0] rEnergyLeft;
  logic [WORD_WIDTH-1:0] rQValue;
  logic [WORD_WIDTH-1:0] rSourceHops;
  logic [WORD_WIDTH-1:0] rDestinationID;
  logic [WORD_WIDTH-1:0] rChosenCH;
  logic [WORD_WIDTH-1:0] rHopsFromCH;
  logic [2:0]            rPacketType;
  logic [5:0]            rTimeslot;

  modport master (
    output en, okToSend,
    input  reward_done, rSourceID, rEnergyLeft, rQValue, rSourceHops,
           rDestinationID, rChosenCH, rHopsFromCH, rPacketType, rTimeslot
  );

  modport slave (
    input  en, okToSend,
    output reward_done, rSourceID, rEnergyLeft, rQValue, rSourceHops,
           rDestinationID, rChosenCH, rHopsFromCH, rPacketType, rTimeslot
  );
endinterface

// File: rtl/reward_nbr_scan.sv
// Neighbor-table scanner: walks the table one entry per cycle looking for the sender's ID.
module reward_nbr_scan #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned MAX_NEIGHBORS = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  active,
  input  logic [WORD_WIDTH-1:0] targetID,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [4:0]            neighborCount,
  output logic [5:0]            index,
  output logic                  finish
);
  import reward_pkg::*;

  logic countBad;
  logic match;
  logic lastEntry;

  always_comb begin
    countBad  = (neighborCount == '0) || (32'(neighborCount) > MAX_NEIGHBORS);
    match     = (mNodeID == targetID);
    lastEntry = ((index + 6'd1) == {1'b0, neighborCount});
    finish    = active && (countBad || match || lastEntry);
  end

  // An empty or oversized table is reported as not-found before any ID compare.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      index <= NOT_FOUND;
    end else if (start) begin
      index <= '0;
    end else if (active) begin
      if (countBad)       index <= NOT_FOUND;
      else if (match)     index <= index;
      else if (lastEntry) index <= NOT_FOUND;
      else                index <= index + 6'd1;
    end
  end

endmodule

// File: rtl/reward_unit.sv
// EER-RL reply-packet builder: latch request, scan neighbors, decide reply, wait for grant, strobe.
// Optional low-energy notification is enabled by defining REWARD_LOW_E_NOTIFY_EN.
module reward_unit #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned MAX_NEIGHBORS = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  reward_unit_if.slave          rsp,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic                  iHaveData,
  input  logic                  iAmDestination,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic                  role,
  input  logic                  low_E,
  input  logic [5:0]            timeslot,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fSourceHops,
  input  logic [WORD_WIDTH-1:0] fQValue,
  input  logic [WORD_WIDTH-1:0] fEnergyLeft,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic [WORD_WIDTH-1:0] fChosenCH,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic [WORD_WIDTH-1:0] chosenHop,
  input  logic [4:0]            neighborCount,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mNodeHops,
  input  logic [WORD_WIDTH-1:0] mNodeQValue,
  input  logic [WORD_WIDTH-1:0] mNodeEnergy,
  input  logic [WORD_WIDTH-1:0] mNodeCHHops,
  output logic [5:0]            nTableIndex_reward
);
  import reward_pkg::*;

  reward_state_t state;

  logic [2:0]            latType;
  logic                  latIAmDest;
  logic [WORD_WIDTH-1:0] latSrcID;
  logic [WORD_WIDTH-1:0] latSrcHops;
  logic [WORD_WIDTH-1:0] latQ;
  logic [WORD_WIDTH-1:0] latEnergy;
  logic [WORD_WIDTH-1:0] latHopsCH;
  logic [WORD_WIDTH-1:0] latChosenCH;

  logic [2:0]            pType;
  logic [WORD_WIDTH-1:0] pDest;
  logic [WORD_WIDTH-1:0] pSrcHops;
  logic [WORD_WIDTH-1:0] pChosenCH;
  logic [WORD_WIDTH-1:0] pHopsCH;
  logic [WORD_WIDTH-1:0] pSrc;
  logic [WORD_WIDTH-1:0] pEnergy;
  logic [WORD_WIDTH-1:0] pQ;
  logic [5:0]            pTimeslot;

  logic [2:0]            dType;
  logic [WORD_WIDTH-1:0] dDest;
  logic [WORD_WIDTH-1:0] dSrcHops;
  logic [WORD_WIDTH-1:0] dChosenCH;
  logic [WORD_WIDTH-1:0] dHopsCH;

  logic scanStart;
  logic scanFinish;

  assign scanStart = (state == ST_IDLE) && rsp.en;

  reward_nbr_scan #(
    .WORD_WIDTH   (WORD_WIDTH),
    .MAX_NEIGHBORS(MAX_NEIGHBORS)
  ) u_scan (
    .clk          (clk),
    .nrst         (nrst),
    .start        (scanStart),
    .active       (state == ST_SCAN),
    .targetID     (latSrcID),
    .mNodeID      (mNodeID),
    .neighborCount(neighborCount),
    .index        (nTableIndex_reward),
    .finish       (scanFinish)
  );

  always_comb begin
    dType     = PKT_INV;
    dDest     = '0;
    dSrcHops  = '0;
    dChosenCH = '0;
    dHopsCH   = '0;
    case (latType)
      PKT_HB: begin
        if (hopsFromSink != '1) begin
          dType    = PKT_HB;
          dDest    = '1;
          dSrcHops = hopsFromSink;
        end
      end
      PKT_CHA: begin
        if (!role) begin
          dType     = PKT_JOIN;
          dDest     = chosenCH;
          dChosenCH = chosenCH;
          dHopsCH   = hopsFromCH;
        end
      end
      PKT_DATA: begin
        if (latIAmDest && (chosenHop != '1)) begin
          dType = PKT_DATA;
          dDest = chosenHop;
        end
      end
      PKT_INV: begin
        if (iHaveData && (chosenHop != '1)) begin
          dType = PKT_DATA;
          dDest = chosenHop;
        end
      end
      default: ;
    endcase
`ifdef REWARD_LOW_E_NOTIFY_EN
    if ((dType != PKT_INV) && low_E) begin
      dType = PKT_LOWE;
      dDest = role ? '1 : chosenCH;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state              <= ST_IDLE;
      latType            <= PKT_INV;
      latIAmDest         <= 1'b0;
      latSrcID           <= '0;
      latSrcHops         <= '0;
      latQ               <= '0;
      latEnergy          <= '0;
      latHopsCH          <= '0;
      latChosenCH        <= '0;
      pType              <= PKT_INV;
      pDest              <= '0;
      pSrcHops           <= '0;
      pChosenCH          <= '0;
      pHopsCH            <= '0;
      pSrc               <= '0;
      pEnergy            <= '0;
      pQ                 <= '0;
      pTimeslot          <= '0;
      rsp.reward_done    <= 1'b0;
      rsp.rSourceID      <= '0;
      rsp.rEnergyLeft    <= '0;
      rsp.rQValue        <= '0;
      rsp.rSourceHops    <= '0;
      rsp.rDestinationID <= '0;
      rsp.rChosenCH      <= '0;
      rsp.rHopsFromCH    <= '0;
      rsp.rPacketType    <= PKT_INV;
      rsp.rTimeslot      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp.reward_done <= 1'b0;
          if (rsp.en) begin
            latType     <= fPacketType;
            latIAmDest  <= iAmDestination;
            latSrcID    <= fSourceID;
            latSrcHops  <= fSourceHops;
            latQ        <= fQValue;
            latEnergy   <= fEnergyLeft;
            latHopsCH   <= fHopsFromCH;
            latChosenCH <= fChosenCH;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scanFinish) state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          pType     <= dType;
          pDest     <= dDest;
          pSrcHops  <= dSrcHops;
          pChosenCH <= dChosenCH;
          pHopsCH   <= dHopsCH;
          pSrc      <= myNodeID;
          pEnergy   <= myEnergy;
          pQ        <= myQValue;
          pTimeslot <= timeslot;
          // No-reply bypasses the grant wait; only the type field is refreshed.
          if (dType == PKT_INV) begin
            rsp.rPacketType <= PKT_INV;
            rsp.reward_done <= 1'b1;
            state           <= ST_DONE;
          end else begin
            state <= ST_WAIT_OK;
          end
        end
        ST_WAIT_OK: begin
          if (rsp.okToSend) begin
            rsp.rPacketType    <= pType;
            rsp.rDestinationID <= pDest;
            rsp.rSourceHops    <= pSrcHops;
            rsp.rChosenCH      <= pChosenCH;
            rsp.rHopsFromCH    <= pHopsCH;
            rsp.rSourceID      <= pSrc;
            rsp.rEnergyLeft    <= pEnergy;
            rsp.rQValue        <= pQ;
            rsp.rTimeslot      <= pTimeslot;
            rsp.reward_done    <= 1'b1;
            state              <= ST_DONE;
          end
        end
        ST_DONE: begin
          rsp.reward_done <= 1'b0;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unusedFields;
  assign unusedFields = ^{latSrcHops, latQ, latEnergy, latHopsCH, latChosenCH,
                          mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops};
`ifndef REWARD_LOW_E_NOTIFY_EN
  logic unusedLowE;
  assign unusedLowE = low_E;
`endif

endmodule

// File: tb/tb_reward_unit.sv
// Randomized self-checking bench for reward_unit against a rule-level reply model.
module tb_reward_unit;
  import reward_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] myEnergy, myNodeID, hopsFromSink, myQValue;
  logic        iHaveData, iAmDestination, role, low_E;
  logic [5:0]  timeslot;
  logic [2:0]  fPacketType;
  logic [15:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
  logic [15:0] chosenCH, hopsFromCH, chosenHop;
  logic [4:0]  neighborCount;
  logic [15:0] mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops;
  logic [5:0]  nTableIndex_reward;
  logic [15:0] tblId [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reward_unit_if #(.WORD_WIDTH(16)) rspIf ();

  assign mNodeID     = (nTableIndex_reward < 6'd16) ? tblId[nTableIndex_reward[3:0]] : 16'h0;
  assign mNodeHops   = mNodeID ^ 16'h00F0;
  assign mNodeQValue = mNodeID ^ 16'h0F00;
  assign mNodeEnergy = mNodeID ^ 16'hF000;
  assign mNodeCHHops = mNodeID ^ 16'h000F;

  reward_unit #(.WORD_WIDTH(16), .MAX_NEIGHBORS(16)) dut (
    .clk(clk), .nrst(nrst), .rsp(rspIf),
    .myEnergy(myEnergy), .iHaveData(iHaveData), .iAmDestination(iAmDestination),
    .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
    .role(role), .low_E(low_E), .timeslot(timeslot), .fPacketType(fPacketType),
    .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fQValue(fQValue),
    .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH),
    .chosenCH(chosenCH), .hopsFromCH(hopsFromCH), .chosenHop(chosenHop),
    .neighborCount(neighborCount), .mNodeID(mNodeID), .mNodeHops(mNodeHops),
    .mNodeQValue(mNodeQValue), .mNodeEnergy(mNodeEnergy), .mNodeCHHops(mNodeCHHops),
    .nTableIndex_reward(nTableIndex_reward)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first table slot holding the sender, or 63 when absent / table invalid.
  function automatic int expIndex();
    int n = int'(neighborCount);
    if (n == 0 || n > 16) return 63;
    for (int i = 0; i < n; i++) if (tblId[i] == fSourceID) return i;
    return 63;
  endfunction

  function automatic int scanCycles(input int idx);
    int n = int'(neighborCount);
    if (n == 0 || n > 16) return 1;
    if (idx != 63) return idx + 1;
    return n;
  endfunction

  task automatic model(output logic [2:0] t, output logic [15:0] d);
    t = PKT_INV;
    d = 16'h0;
    if (fPacketType == PKT_HB && hopsFromSink != 16'hFFFF) begin
      t = PKT_HB; d = BROADCAST_ID;
    end else if (fPacketType == PKT_CHA && !role) begin
      t = PKT_JOIN; d = chosenCH;
    end else if (((fPacketType == PKT_DATA && iAmDestination) ||
                  (fPacketType == PKT_INV && iHaveData)) && chosenHop != 16'hFFFF) begin
      t = PKT_DATA; d = chosenHop;
    end
`ifdef REWARD_LOW_E_NOTIFY_EN
    if (t != PKT_INV && low_E) begin
      t = PKT_LOWE; d = role ? 16'hFFFF : chosenCH;
    end
`endif
  endtask

  task automatic setDefaults();
    myEnergy = 16'h7FFC; myNodeID = 16'h000C; hopsFromSink = 16'h0001; myQValue = 16'h0123;
    iHaveData = 1'b0; iAmDestination = 1'b0; role = 1'b0; low_E = 1'b0; timeslot = 6'd9;
    fPacketType = PKT_HB; fSourceID = 16'h0; fSourceHops = 16'h2; fQValue = 16'h3;
    fEnergyLeft = 16'h4; fHopsFromCH = 16'h5; fChosenCH = 16'h6;
    chosenCH = 16'h0005; hopsFromCH = 16'h0002; chosenHop = 16'h0007; neighborCount = 5'd0;
    for (int i = 0; i < 16; i++) tblId[i] = 16'h1000 + 16'(i);
  endtask

  // One transaction; okToSend is high at every edge numbered >= okEdge (edge 0 samples en).
  task automatic runTxn(input string tag, input int okEdge, input int pulseAgainAt, input bit scramble);
    logic [2:0]  et;
    logic [15:0] ed;
    logic [2:0]  origType;
    int ei, s, expDone, doneAt;
    model(et, ed);
    origType = fPacketType;
    ei = expIndex();
    s = scanCycles(ei);
    if (et == PKT_INV) expDone = s + 1;
    else expDone = (s + 2 > okEdge) ? s + 2 : okEdge;
    @(negedge clk);
    rspIf.en = 1'b1;
    rspIf.okToSend = (okEdge <= 0);
    doneAt = -1;
    for (int e = 0; e < 300 && doneAt < 0; e++) begin
      @(posedge clk); #1;
      if (rspIf.reward_done) doneAt = e;
      if (e == 0) begin
        rspIf.en = 1'b0;
        if (scramble) begin
          fPacketType = 3'($urandom); fSourceID = 16'($urandom); iAmDestination = 1'($urandom);
        end
      end
      if (e == pulseAgainAt) rspIf.en = 1'b1;
      else if (e == pulseAgainAt + 1) rspIf.en = 1'b0;
      rspIf.okToSend = (e + 1 >= okEdge);
    end
    rspIf.en = 1'b0;
    check({tag, ".latency"}, doneAt, expDone);
    check({tag, ".type"}, rspIf.rPacketType, et);
    check({tag, ".index"}, nTableIndex_reward, ei);
    if (et != PKT_INV) begin
      check({tag, ".dest"}, rspIf.rDestinationID, ed);
      check({tag, ".src"}, rspIf.rSourceID, myNodeID);
      check({tag, ".energy"}, rspIf.rEnergyLeft, myEnergy);
      check({tag, ".qval"}, rspIf.rQValue, myQValue);
      check({tag, ".slot"}, rspIf.rTimeslot, timeslot);
      if (origType == PKT_HB) check({tag, ".hops"}, rspIf.rSourceHops, hopsFromSink);
      if (origType == PKT_CHA) begin
        check({tag, ".ch"}, rspIf.rChosenCH, chosenCH);
        check({tag, ".chhops"}, rspIf.rHopsFromCH, hopsFromCH);
      end
    end
    @(posedge clk); #1;
    check({tag, ".doneWidth"}, rspIf.reward_done, 1'b0);
    rspIf.okToSend = 1'b0;
  endtask

  initial begin
    int doneSeen;
    logic [2:0] pick [6];
    pick[0] = PKT_HB; pick[1] = PKT_CHA; pick[2] = PKT_JOIN;
    pick[3] = PKT_DATA; pick[4] = PKT_LOWE; pick[5] = PKT_INV;
    rspIf.en = 1'b0;
    rspIf.okToSend = 1'b0;
    setDefaults();
    nrst = 1'b0;
    @(posedge clk); #1;
    check("rst.type", rspIf.rPacketType, 3'b111);
    check("rst.index", nTableIndex_reward, 6'h3F);
    check("rst.done", rspIf.reward_done, 1'b0);
    check("rst.src", rspIf.rSourceID, 16'h0);
    check("rst.dest", rspIf.rDestinationID, 16'h0);
    check("rst.slot", rspIf.rTimeslot, 6'h0);
    @(negedge clk); nrst = 1'b1;

    runTxn("hb", 2, -10, 1'b0);
    check("hb.constDest", rspIf.rDestinationID, 16'hFFFF);

    fPacketType = PKT_CHA; fSourceID = 16'h0042; tblId[3] = 16'h0042; neighborCount = 5'd8;
    runTxn("cha0", 0, -10, 1'b0);
    check("cha0.constIdx", nTableIndex_reward, 6'd3);
    role = 1'b1;
    runTxn("cha1", 0, -10, 1'b0);

    setDefaults();
    fPacketType = PKT_DATA; iAmDestination = 1'b1; fSourceID = 16'h1000; neighborCount = 5'd4;
    runTxn("fwd", 0, -10, 1'b0);
    chosenHop = 16'hFFFF;
    runTxn("fwdBcast", 0, -10, 1'b0);

    setDefaults();
    fSourceID = 16'h100F; neighborCount = 5'd16;
    runTxn("full", 1, -10, 1'b0);

    setDefaults();
    runTxn("backpressure", 14, 5, 1'b0);
    rspIf.okToSend = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rspIf.reward_done) doneSeen++;
    end
    rspIf.okToSend = 1'b0;
    check("backpressure.ignoredEn", doneSeen, 0);

    setDefaults();
    low_E = 1'b1;
    runTxn("lowE", 0, -10, 1'b0);

    setDefaults();
    rspIf.okToSend = 1'b1;
    @(negedge clk); rspIf.en = 1'b1;
    @(negedge clk); rspIf.en = 1'b0;
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rspIf.reward_done) doneSeen++;
    end
    rspIf.okToSend = 1'b0;
    check("abort.done", doneSeen, 0);
    check("abort.type", rspIf.rPacketType, 3'b111);
    check("abort.index", nTableIndex_reward, 6'h3F);

    for (int t = 0; t < 60; t++) begin
      fPacketType = pick[$urandom_range(0, 5)];
      role = 1'($urandom); iAmDestination = 1'($urandom); iHaveData = 1'($urandom);
      low_E = 1'($urandom);
      hopsFromSink = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      chosenHop = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      chosenCH = 16'($urandom); hopsFromCH = 16'($urandom);
      myNodeID = 16'($urandom); myEnergy = 16'($urandom); myQValue = 16'($urandom);
      timeslot = 6'($urandom);
      neighborCount = 5'($urandom_range(0, 20));
      fSourceID = 16'($urandom);
      for (int i = 0; i < 16; i++) tblId[i] = 16'($urandom);
      if ($urandom_range(0, 2) != 0) tblId[$urandom_range(0, 15)] = fSourceID;
      runTxn($sformatf("rnd%0d", t), $urandom_range(0, 6), -10, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reward_unit.md
Name: reward_unit

Overview:
- Response-packet builder for the EER-RL node datapath, placed after packetFilter and alongside MY_NODE_INFO, KCH, QTUFMB and neighborTable.
- On an `en` pulse it latches the received packet fields and scans the neighbor table for the sender's entry.
- It then decides the reply packet and assembles the `r*` outgoing fields.
- It waits for `okToSend`, then presents the packet with a one-cycle `reward_done` strobe.

Parameters:
- WORD_WIDTH, 16, width of IDs, hops, energy, Q-values.
- MAX_NEIGHBORS, 16, neighbor-table depth; a `neighborCount` above this is treated as 0.

Ports:
- clk in 1 system clock
- nrst in 1 reset, synchronous, active-low
- en in 1 one-cycle start pulse
- myEnergy in 16 residual energy
- iHaveData in 1 node has local data to originate
- okToSend in 1 channel/timeslot grant
- iAmDestination in 1 packetFilter: this node is the addressee
- myNodeID, hopsFromSink, myQValue in 16 each own node info
- role in 1 0 = member, 1 = cluster head
- low_E in 1 energy below threshold
- timeslot in 6 assigned TDMA slot
- fPacketType in 3 received type
- fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH in 16 each received fields
- chosenCH, hopsFromCH in 16 each from KCH
- chosenHop in 16 from QTUFMB, next hop
- neighborCount in 5 valid neighbor entries
- mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops in 16 each neighbor entry at nTableIndex_reward (combinational read)
- rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH out 16 each reply fields
- rPacketType out 3 reply type
- rTimeslot out 6 reply timeslot
- nTableIndex_reward out 6 neighbor-table address / match index
- reward_done out 1 reply valid strobe

Behaviour:
- Clock and reset: one clock `clk`; `nrst` is synchronous and active-low. All state is in registers.
- Reset values: every `r*` 16-bit output is 0; `rPacketType`=3'b111; `rTimeslot`=0; `nTableIndex_reward`=6'h3F; `reward_done`=0; FSM goes to IDLE.
- Packet types: 000 heartbeat, 001 CH announce, 010 join, 011 data, 101 low-energy notice, 111 invalid/none.
- IDLE:
  - On `en`, latch all `f*` fields and `iAmDestination`.
  - Set `nTableIndex_reward`=0 and go to SCAN.
  - `en` outside IDLE is ignored.
- SCAN, one entry per cycle:
  - If `mNodeID`==latched `fSourceID`, hold that index and go to DECIDE.
  - Otherwise increment the index.
  - If the index reaches `neighborCount` (or `neighborCount` is 0 or above MAX_NEIGHBORS), set the index to 6'h3F (not found) and go to DECIDE.
  - Worst case is MAX_NEIGHBORS+1 cycles.
- DECIDE, one cycle; compute the reply from the latched type:
  - 000: if `hopsFromSink` != 16'hFFFF, reply heartbeat 000.
    - `rDestinationID`=16'hFFFF; `rSourceHops`=`hopsFromSink`.
  - 001: if `role`=0, reply join 010.
    - `rDestinationID`=`chosenCH`; `rChosenCH`=`chosenCH`; `rHopsFromCH`=`hopsFromCH`.
    - If `role`=1, no reply.
  - 011 with `iAmDestination`=1: forward data 011.
    - `rDestinationID`=`chosenHop`.
  - 111 with `iHaveData`=1: originate data 011 to `chosenHop`.
  - All other cases: no reply. Skip WAIT_OK, go to DONE with `rPacketType`=111.
  - Common fields for any reply: `rSourceID`=`myNodeID`; `rEnergyLeft`=`myEnergy`; `rQValue`=`myQValue`; `rTimeslot`=`timeslot`.
  - A data reply with `chosenHop`==16'hFFFF is treated as no reply.
- WAIT_OK: stay until `okToSend`=1. If `okToSend` is already high, leave on the next cycle.
- DONE:
  - Update the `r*` registers and assert `reward_done` for exactly one cycle; return to IDLE.
  - `r*` and `nTableIndex_reward` hold until the next DONE or reset.
- Minimum latency `en` → `reward_done`: 3 cycles (SCAN with an immediate match, DECIDE, DONE, `okToSend` already high).
- Reset mid-operation aborts with no `reward_done`.

Optional Feature:
- Macro: REWARD_LOW_E_NOTIFY_EN.
- Defined: when `low_E`=1 at DECIDE and a reply would be sent, the type becomes 101 and `rDestinationID`=`chosenCH` if `role`=0, else 16'hFFFF. Other fields are unchanged.
- Undefined: `low_E` is ignored.

Decomposition:
- Package `reward_pkg`: WORD_WIDTH, packet-type localparams (PKT_HB, PKT_CHA, PKT_JOIN, PKT_DATA, PKT_LOWE, PKT_INV), BROADCAST_ID=16'hFFFF, NOT_FOUND=6'h3F, FSM state enum.
- One natural sub-module, `reward_nbr_scan`: the SCAN index counter and ID comparator.

Test Plan:
- Reset: `nrst`=0 for 1 cycle → `rPacketType`=111, `nTableIndex_reward`=3F, `reward_done`=0, `r*`=0.
- Heartbeat:
  - Stimulus: `fPacketType`=000, `fSourceID`=0, `hopsFromSink`=1, `myNodeID`=000C, `myEnergy`=7FFC, `neighborCount`=0, `en` pulse, `okToSend` 2 cycles later.
  - Response: one `reward_done` after `okToSend`; `rPacketType`=000, `rSourceID`=000C, `rSourceHops`=1, `rDestinationID`=FFFF, `rEnergyLeft`=7FFC, `nTableIndex_reward`=3F.
- CH announce: `role`=0, `chosenCH`=0005, `hopsFromCH`=2, `fSourceID` at table index 3 → `nTableIndex_reward`=3; reply 010 with dest 0005 and `rHopsFromCH`=2. With `role`=1 → `rPacketType`=111, `reward_done` still pulses.
- Data forward: `fPacketType`=011, `iAmDestination`=1, `chosenHop`=0007 → reply 011 with dest 0007. With `chosenHop`=FFFF → no reply (111).
- Backpressure: `okToSend` held 0 for 10 cycles → no `reward_done`; a second `en` pulse during the wait is ignored.
- REWARD_LOW_E_NOTIFY_EN: `low_E`=1 with heartbeat and `role`=0, `chosenCH`=0005 → `rPacketType`=101, dest 0005. Macro undefined → 000.
